// File: rtl/drum_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : drum_step_sequencer
//  Purpose  : Tempo and step generator for the four-instrument drum machine.
//             A phase accumulator in the system clock domain converts the
//             selected BPM into an 8-step cyclic position (timing 1..8, 0 when
//             stopped) and a play enable for the pattern datapath.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  system clock, rising edge
//    reset      in   1  synchronous reset, active low
//    start      in   1  start from IDLE / resume from PAUSE (level)
//    pause      in   1  freeze position while running (level)
//    stop       in   1  return to IDLE from any state (level)
//    bpm        in   8  requested tempo, floored at MIN_BPM
//    timing     out  4  current step 1..8, 0 in IDLE
//    play       out  1  high in RUN and PAUSE
//    step_pulse out  1  one-cycle strobe on every step entry
//    bar_pulse  out  1  one-cycle strobe on entry to step 1
// ============================================================================
module drum_step_sequencer #(
   parameter int unsigned CLK_HZ         = 50_000_000,
   parameter int unsigned STEPS_PER_BEAT = 2,
   parameter int unsigned MIN_BPM        = 40,
   parameter int unsigned ACC_W          = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic [7:0] bpm,
   output logic [3:0] timing,
   output logic       play,
   output logic       step_pulse,
   output logic       bar_pulse
);

   // One step is one crossing of CLK_HZ*60 by the accumulated bpm*steps.
   // Computed in 64 bits so the product cannot overflow before truncation.
   localparam logic [ACC_W-1:0] c_T       = ACC_W'(64'(CLK_HZ) * 64'd60);
   localparam logic [ACC_W-1:0] c_INC_RST = ACC_W'(64'(MIN_BPM) * 64'(STEPS_PER_BEAT));
   localparam logic [7:0]       c_MIN_BPM = 8'(MIN_BPM);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_inc;
   logic [3:0]       r_timing;
   logic             r_step_pulse;
   logic             r_bar_pulse;

   state_t           w_state_nxt;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [ACC_W-1:0] w_inc_nxt;
   logic [3:0]       w_timing_nxt;
   logic             w_step_nxt;
   logic             w_bar_nxt;

   logic [7:0]       w_bpm_eff;
   logic [ACC_W-1:0] w_inc_new;
   logic [ACC_W-1:0] w_sum;
   logic [3:0]       w_timing_adv;

   assign w_bpm_eff    = (bpm < c_MIN_BPM) ? c_MIN_BPM : bpm;
   assign w_inc_new    = ACC_W'(w_bpm_eff) * ACC_W'(STEPS_PER_BEAT);
   // acc stays below T, so acc+inc fits ACC_W given the width constraint.
   assign w_sum        = r_acc + r_inc;
   assign w_timing_adv = (r_timing == 4'd8) ? 4'd1 : r_timing + 4'd1;

   // ---------------------------------------------------------------------
   // State register and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_inc        <= c_INC_RST;
         r_timing     <= 4'd0;
         r_step_pulse <= 1'b0;
         r_bar_pulse  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_inc        <= w_inc_nxt;
         r_timing     <= w_timing_nxt;
         r_step_pulse <= w_step_nxt;
         r_bar_pulse  <= w_bar_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. stop outranks start/pause in every state.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_inc_nxt    = r_inc;
      w_timing_nxt = r_timing;
      w_step_nxt   = 1'b0;
      w_bar_nxt    = 1'b0;

      if (stop) begin
         w_state_nxt  = S_IDLE;
         w_acc_nxt    = '0;
         w_timing_nxt = 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt  = S_RUN;
                  w_acc_nxt    = '0;
                  w_inc_nxt    = w_inc_new;
                  w_timing_nxt = 4'd1;
                  w_step_nxt   = 1'b1;
                  w_bar_nxt    = 1'b1;
               end
            end
            S_RUN: begin
               // pause beats a tick on the same edge; the advance is
               // deferred because acc is left untouched.
               if (pause) begin
                  w_state_nxt = S_PAUSE;
               end else if (w_sum >= c_T) begin
                  // Keep the remainder so the average rate never drifts;
                  // a new tempo is only picked up on a step boundary.
                  w_acc_nxt    = w_sum - c_T;
                  w_inc_nxt    = w_inc_new;
                  w_timing_nxt = w_timing_adv;
                  w_step_nxt   = 1'b1;
                  w_bar_nxt    = (w_timing_adv == 4'd1);
               end else begin
                  w_acc_nxt = w_sum;
               end
            end
            S_PAUSE: begin
               // Resume does not accumulate or strobe on its own edge.
               if (start) begin
                  w_state_nxt = S_RUN;
               end
            end
            default: begin
               w_state_nxt  = S_IDLE;
               w_acc_nxt    = '0;
               w_timing_nxt = 4'd0;
            end
         endcase
      end
   end

   assign timing     = r_timing;
   assign play       = (r_state != S_IDLE);
   assign step_pulse = r_step_pulse;
   assign bar_pulse  = r_bar_pulse;

endmodule
`default_nettype wire

// File: tb/tb_drum_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drum_step_sequencer
//  Purpose  : Self-checking bench for drum_step_sequencer: directed tempo,
//             pause, stop and reset scenarios followed by randomized control
//             traffic, all compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drum_step_sequencer;

   localparam int c_CLK_HZ = 100;
   localparam int c_SPB    = 2;
   localparam int c_MINB   = 40;
   localparam int c_T      = c_CLK_HZ * 60;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       stop  = 1'b0;
   logic [7:0] bpm   = 8'd120;
   logic [3:0] timing;
   logic       play;
   logic       step_pulse;
   logic       bar_pulse;

   always #5 clk = ~clk;

   drum_step_sequencer #(
      .CLK_HZ         (c_CLK_HZ),
      .STEPS_PER_BEAT (c_SPB),
      .MIN_BPM        (c_MINB),
      .ACC_W          (32)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .bpm        (bpm),
      .timing     (timing),
      .play       (play),
      .step_pulse (step_pulse),
      .bar_pulse  (bar_pulse)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int q_step[$];
   int q_bar[$];

   // Reference model: mode 0 = stopped, 1 = running, 2 = paused.
   int m_mode = 0;
   int m_acc  = 0;
   int m_inc  = c_MINB * c_SPB;
   int m_pos  = 0;
   bit m_sp   = 0;
   bit m_bp   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int tempo_inc(input int b);
      return ((b < c_MINB) ? c_MINB : b) * c_SPB;
   endfunction

   task automatic model_step();
      m_sp = 0;
      m_bp = 0;
      if (!reset) begin
         m_mode = 0; m_acc = 0; m_inc = c_MINB * c_SPB; m_pos = 0;
      end else if (stop) begin
         m_mode = 0; m_acc = 0; m_pos = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_mode = 1; m_acc = 0; m_inc = tempo_inc(int'(bpm)); m_pos = 0;
            m_sp = 1; m_bp = 1;
         end
      end else if (m_mode == 1) begin
         if (pause) begin
            m_mode = 2;
         end else begin
            m_acc += m_inc;
            if (m_acc >= c_T) begin
               m_acc -= c_T;
               m_pos = (m_pos + 1) % 8;
               m_sp  = 1;
               m_bp  = (m_pos == 0);
               m_inc = tempo_inc(int'(bpm));
            end
         end
      end else begin
         if (start) m_mode = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check_eq("timing", 32'(timing), (m_mode == 0) ? 32'd0 : 32'(m_pos + 1));
      check_eq("play", 32'(play), (m_mode != 0) ? 32'd1 : 32'd0);
      check_eq("step_pulse", 32'(step_pulse), 32'(m_sp));
      check_eq("bar_pulse", 32'(bar_pulse), 32'(m_bp));
      if (step_pulse === 1'b1) q_step.push_back(cyc);
      if (bar_pulse === 1'b1) q_bar.push_back(cyc);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_timing(input logic [3:0] v, input int budget);
      int k;
      k = 0;
      while (timing !== v && k < budget) begin
         tick();
         k++;
      end
      check_eq("wait_timing", 32'(timing), 32'(v));
   endtask

   task automatic go_idle();
      start = 1'b0; pause = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic fresh_start(input logic [7:0] b);
      go_idle();
      bpm = b;
      q_step.delete();
      q_bar.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_gaps(input string tag, input int exp_gap, input int n);
      if (q_step.size() < n + 1) begin
         check_eq({tag, "_count"}, 32'(q_step.size()), 32'(n + 1));
      end else begin
         for (int i = 0; i < n; i++)
            check_eq(tag, 32'(q_step[i+1] - q_step[i]), 32'(exp_gap));
      end
   endtask

   initial begin
      int k;

      // Reset state
      ticks(3);
      check_eq("rst_timing", 32'(timing), 32'd0);
      check_eq("rst_play", 32'(play), 32'd0);
      check_eq("rst_step", 32'(step_pulse), 32'd0);
      reset = 1'b1;

      // 120 BPM: 25-cycle steps, 200-cycle bars
      fresh_start(8'd120);
      check_eq("start_timing", 32'(timing), 32'd1);
      check_eq("start_bar", 32'(bar_pulse), 32'd1);
      ticks(420);
      check_gaps("gap120", 25, 16);
      if (q_bar.size() < 3) check_eq("bar_count", 32'(q_bar.size()), 32'd3);
      else for (int i = 0; i < 2; i++) check_eq("bar_gap", 32'(q_bar[i+1] - q_bar[i]), 32'd200);

      // Floor applied to 0 and 20 BPM: 75-cycle steps
      fresh_start(8'd0);
      ticks(160);
      check_gaps("gap_bpm0", 75, 2);
      fresh_start(8'd20);
      ticks(160);
      check_gaps("gap_bpm20", 75, 2);

      // Pause 10 cycles into step 3, resume 15 cycles before step 4
      fresh_start(8'd120);
      wait_timing(4'd3, 100);
      ticks(10);
      pause = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check_eq("pause_hold", 32'(timing), 32'd3);
      end
      pause = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("resume_nostrobe", 32'(step_pulse), 32'd0);
      k = 0;
      do begin
         tick();
         k++;
      end while (step_pulse !== 1'b1 && k < 40);
      check_eq("resume_gap", 32'(k), 32'd15);
      check_eq("resume_timing", 32'(timing), 32'd4);

      // Tempo change mid-step 2 takes effect from step 3
      fresh_start(8'd120);
      wait_timing(4'd2, 100);
      ticks(5);
      bpm = 8'd240;
      wait_timing(4'd6, 200);
      if (q_step.size() < 6) check_eq("bpmchg_count", 32'(q_step.size()), 32'd6);
      else begin
         check_eq("bpmchg_s2", 32'(q_step[2] - q_step[1]), 32'd25);
         check_eq("bpmchg_s3", 32'(q_step[3] - q_step[2]), 32'd13);
         check_eq("bpmchg_s4", 32'(q_step[4] - q_step[3]), 32'd12);
         check_eq("bpmchg_s5", 32'(q_step[5] - q_step[4]), 32'd13);
      end

      // stop beats start in step 6; restart enters step 1 with bar strobe
      bpm = 8'd120;
      wait_timing(4'd6, 300);
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      check_eq("stop_timing", 32'(timing), 32'd0);
      check_eq("stop_play", 32'(play), 32'd0);
      ticks(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("restart_timing", 32'(timing), 32'd1);
      check_eq("restart_bar", 32'(bar_pulse), 32'd1);

      // Reset during PAUSE at step 5, start ignored while reset low
      wait_timing(4'd5, 200);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      ticks(3);
      reset = 1'b0; start = 1'b1;
      tick();
      check_eq("rstp_timing", 32'(timing), 32'd0);
      check_eq("rstp_play", 32'(play), 32'd0);
      check_eq("rstp_step", 32'(step_pulse), 32'd0);
      reset = 1'b1; start = 1'b0;
      tick();
      check_eq("rstp_idle", 32'(timing), 32'd0);

      // Randomized control traffic
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 199) != 0);
         stop  = ($urandom_range(0, 149) == 0);
         start = ($urandom_range(0, 19) == 0);
         pause = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 49) == 0) bpm = 8'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
